// File: rtl/clock_set_controller.sv
// rtl/clock_set_controller.sv - mode/set/alarm controller for a 1 Hz hh:mm:ss timekeeper
module clock_set_controller #(
    parameter int HOURS_MAX    = 24,
    parameter int MINUTES_MAX  = 60,
    parameter int RING_SECONDS = 60
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       tick_en,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_alarm,
    input  logic [4:0] cur_hours,
    input  logic [5:0] cur_minutes,
    input  logic [5:0] cur_seconds,
    output logic       count_en,
    output logic       load,
    output logic [4:0] load_hours,
    output logic [5:0] load_minutes,
    output logic [2:0] mode,
    output logic [4:0] alarm_hours,
    output logic [5:0] alarm_minutes,
    output logic       alarm_on,
    output logic       alarm_ring
);

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        SET_H  = 3'd1,
        SET_M  = 3'd2,
        SET_AH = 3'd3,
        SET_AM = 3'd4
    } mode_t;

    localparam logic [5:0] HOUR_LAST   = 6'(HOURS_MAX - 1);
    localparam logic [5:0] MINUTE_LAST = 6'(MINUTES_MAX - 1);
    localparam logic [7:0] RING_INIT   = 8'(RING_SECONDS);

    mode_t      state;
    logic [4:0] edit_h;
    logic [5:0] edit_m;
    logic [7:0] ring_cnt;
    logic       match;
    logic       match_d;
    logic       any_btn;

    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] last);
        return (v == last) ? 6'd0 : v + 6'd1;
    endfunction

    assign mode     = state;
    assign count_en = tick_en && (state != SET_H) && (state != SET_M);
    assign any_btn  = btn_mode || btn_inc || btn_alarm;
    assign match    = alarm_on && (cur_hours == alarm_hours) &&
                      (cur_minutes == alarm_minutes) && (cur_seconds == 6'd0);

    always_ff @(posedge Clk) begin
        if (reset) begin
            state         <= RUN;
            edit_h        <= '0;
            edit_m        <= '0;
            alarm_hours   <= '0;
            alarm_minutes <= '0;
            alarm_on      <= 1'b0;
            alarm_ring    <= 1'b0;
            ring_cnt      <= '0;
            match_d       <= 1'b0;
            load          <= 1'b0;
            load_hours    <= '0;
            load_minutes  <= '0;
        end else begin
            load    <= 1'b0;
            match_d <= match;
            // A press while ringing only silences; it never reaches the mode logic.
            if (alarm_ring && any_btn) begin
                alarm_ring <= 1'b0;
                ring_cnt   <= '0;
            end else begin
                if (match && !match_d && !alarm_ring) begin
                    alarm_ring <= 1'b1;
                    ring_cnt   <= RING_INIT;
                end else if (alarm_ring && tick_en) begin
                    ring_cnt <= ring_cnt - 8'd1;
                    if (ring_cnt == 8'd1)
                        alarm_ring <= 1'b0;
                end

                case (state)
                    RUN: begin
                        if (btn_mode) begin
                            state  <= SET_H;
                            edit_h <= cur_hours;
                            edit_m <= cur_minutes;
                        end else if (btn_alarm && !btn_inc) begin
                            alarm_on <= ~alarm_on;
                        end
                    end
                    SET_H: begin
                        if (btn_mode)
                            state <= SET_M;
                        else if (btn_inc)
                            edit_h <= 5'(wrap_inc({1'b0, edit_h}, HOUR_LAST));
                    end
                    SET_M: begin
                        if (btn_mode) begin
                            state        <= SET_AH;
                            load         <= 1'b1;
                            load_hours   <= edit_h;
                            load_minutes <= edit_m;
                        end else if (btn_inc) begin
                            edit_m <= wrap_inc(edit_m, MINUTE_LAST);
                        end
                    end
                    SET_AH: begin
                        if (btn_mode)
                            state <= SET_AM;
                        else if (btn_inc)
                            alarm_hours <= 5'(wrap_inc({1'b0, alarm_hours}, HOUR_LAST));
                    end
                    SET_AM: begin
                        if (btn_mode)
                            state <= RUN;
                        else if (btn_inc)
                            alarm_minutes <= wrap_inc(alarm_minutes, MINUTE_LAST);
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clock_set_controller.sv
// tb/tb_clock_set_controller.sv - directed and random checks of clock_set_controller
module tb_clock_set_controller;

    localparam int HM = 24;
    localparam int MM = 60;
    localparam int RS = 8;

    logic       Clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick_en = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_alarm = 1'b0;
    logic [4:0] cur_hours = '0;
    logic [5:0] cur_minutes = '0;
    logic [5:0] cur_seconds = '0;
    logic       count_en;
    logic       load;
    logic [4:0] load_hours;
    logic [5:0] load_minutes;
    logic [2:0] mode;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic       alarm_on;
    logic       alarm_ring;

    clock_set_controller #(
        .HOURS_MAX(HM), .MINUTES_MAX(MM), .RING_SECONDS(RS)
    ) dut (
        .Clk(Clk), .reset(reset), .tick_en(tick_en),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_alarm(btn_alarm),
        .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
        .count_en(count_en), .load(load), .load_hours(load_hours),
        .load_minutes(load_minutes), .mode(mode), .alarm_hours(alarm_hours),
        .alarm_minutes(alarm_minutes), .alarm_on(alarm_on), .alarm_ring(alarm_ring)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;
    int ce_seen = 0;

    // Reference model: mode index 0..4 in panel order, ring as seconds remaining.
    bit m_valid = 0;
    int m_mode, m_eh, m_em, m_ah, m_am, m_lh, m_lm, m_left;
    bit m_on, m_ring, m_load, m_prev_match;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit m, input bit i, input bit a, input bit t);
        bit now_match;
        now_match = m_on && int'(cur_hours) == m_ah && int'(cur_minutes) == m_am && cur_seconds == 0;
        m_load = 0;
        if (r) begin
            m_mode = 0; m_eh = 0; m_em = 0; m_ah = 0; m_am = 0;
            m_on = 0; m_ring = 0; m_left = 0; m_prev_match = 0; m_lh = 0; m_lm = 0;
            return;
        end
        if (m_ring && (m || i || a)) begin
            m_ring = 0;
            m_left = 0;
        end else begin
            if (now_match && !m_prev_match && !m_ring) begin
                m_ring = 1;
                m_left = RS;
            end else if (m_ring && t) begin
                m_left--;
                if (m_left == 0) m_ring = 0;
            end
            if (m) begin
                if (m_mode == 0) begin m_eh = int'(cur_hours); m_em = int'(cur_minutes); end
                if (m_mode == 2) begin m_load = 1; m_lh = m_eh; m_lm = m_em; end
                m_mode = (m_mode + 1) % 5;
            end else if (i) begin
                case (m_mode)
                    1: m_eh = (m_eh + 1) % HM;
                    2: m_em = (m_em + 1) % MM;
                    3: m_ah = (m_ah + 1) % HM;
                    4: m_am = (m_am + 1) % MM;
                    default: ;
                endcase
            end else if (a && m_mode == 0) begin
                m_on = !m_on;
            end
        end
        m_prev_match = now_match;
    endtask

    task automatic cycle(input bit r, input bit m, input bit i, input bit a, input bit t);
        reset = r; btn_mode = m; btn_inc = i; btn_alarm = a; tick_en = t;
        #1;
        if (m_valid) chk("count_en", count_en, t && m_mode != 1 && m_mode != 2);
        if (count_en === 1'b1) ce_seen++;
        @(posedge Clk);
        #1;
        model_step(r, m, i, a, t);
        if (r) m_valid = 1;
        if (m_valid) begin
            chk("mode", mode, m_mode);
            chk("load", load, m_load);
            chk("load_hours", load_hours, m_lh);
            chk("load_minutes", load_minutes, m_lm);
            chk("alarm_hours", alarm_hours, m_ah);
            chk("alarm_minutes", alarm_minutes, m_am);
            chk("alarm_on", alarm_on, m_on);
            chk("alarm_ring", alarm_ring, m_ring);
        end
        @(negedge Clk);
    endtask

    task automatic set_cur(input int h, input int mi, input int s);
        cur_hours = 5'(h); cur_minutes = 6'(mi); cur_seconds = 6'(s);
    endtask

    initial begin
        @(negedge Clk);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        chk("reset_mode", mode, 0);
        chk("reset_load", load, 0);
        chk("reset_ring", alarm_ring, 0);
        chk("reset_alarm_on", alarm_on, 0);

        set_cur(12, 0, 5);
        ce_seen = 0;
        for (int k = 0; k < 5; k++) cycle(0, 0, 0, 0, 1);
        chk("run_count_en_pulses", ce_seen, 5);

        set_cur(10, 15, 30);
        cycle(0, 1, 0, 0, 1);
        ce_seen = 0;
        for (int k = 0; k < 15; k++) cycle(0, 0, 1, 0, 1);
        cycle(0, 1, 0, 0, 1);
        for (int k = 0; k < 2; k++) cycle(0, 0, 1, 0, 1);
        chk("edit_count_en_frozen", ce_seen, 0);
        cycle(0, 1, 0, 0, 0);
        chk("set_load_strobe", load, 1);
        chk("set_load_hours", load_hours, 1);
        chk("set_load_minutes", load_minutes, 17);
        chk("set_mode_ah", mode, 3);
        cycle(0, 0, 0, 0, 0);
        chk("load_one_cycle", load, 0);
        chk("load_hours_hold", load_hours, 1);

        cycle(0, 0, 0, 1, 0);
        chk("alarm_btn_in_set_ah", alarm_on, 0);
        for (int k = 0; k < 7; k++) cycle(0, 0, 1, 0, 0);
        cycle(0, 1, 0, 0, 0);
        for (int k = 0; k < 30; k++) cycle(0, 0, 1, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        chk("alarm_armed", alarm_on, 1);
        chk("alarm_h_set", alarm_hours, 7);
        chk("alarm_m_set", alarm_minutes, 30);

        set_cur(3, 58, 10);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 1, 1, 0, 0);
        chk("wrap_mode_adv", mode, 3);
        chk("wrap_load_minutes", load_minutes, 0);
        chk("wrap_load_hours", load_hours, 3);
        chk("mode_inc_no_alarm_inc", alarm_hours, 7);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);

        set_cur(7, 29, 59);
        cycle(0, 0, 0, 0, 1);
        chk("no_ring_before_match", alarm_ring, 0);
        set_cur(7, 30, 0);
        cycle(0, 0, 0, 0, 0);
        chk("ring_after_match", alarm_ring, 1);
        for (int k = 0; k < RS; k++) begin
            cycle(0, 0, 0, 0, 1);
            chk("ring_duration", alarm_ring, k < RS - 1);
        end
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, 1);
        chk("no_retrigger_hold", alarm_ring, 0);

        set_cur(7, 31, 0);
        cycle(0, 0, 0, 0, 0);
        set_cur(7, 30, 0);
        cycle(0, 0, 0, 0, 0);
        chk("ring_again", alarm_ring, 1);
        cycle(0, 1, 0, 0, 0);
        chk("silence_ring", alarm_ring, 0);
        chk("silence_mode_run", mode, 0);
        chk("silence_alarm_on", alarm_on, 1);

        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        chk("in_set_m", mode, 2);
        cycle(1, 0, 0, 0, 0);
        chk("reset_mid_edit_mode", mode, 0);
        chk("reset_mid_edit_load", load, 0);
        chk("reset_alarm_h", alarm_hours, 0);
        chk("reset_alarm_m", alarm_minutes, 0);
        cycle(0, 0, 0, 0, 0);
        chk("no_load_after_reset", load, 0);

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) < 2) begin
                set_cur(m_ah, m_am, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 59)));
            end else begin
                set_cur(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                        int'($urandom_range(0, 59)));
            end
            cycle($urandom_range(0, 599) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
